// File: rtl/bridge_pkg.sv
// bridge_pkg: shared types and constants for the bridge request arbiter.
//   arb_state_e        - arbiter FSM state encoding
//   OPCODE_W           - width of a request opcode
//   REQ_RESULT_TIMEOUT - result reported when an outstanding grant is aborted
//   gw_of()            - width of a channel index (never less than 1)
package bridge_pkg;

  localparam int OPCODE_W = 16;
  localparam logic [15:0] REQ_RESULT_TIMEOUT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

  function automatic int gw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_rr_pick.sv
// bridge_rr_pick: combinational round-robin picker.
// Returns the first set request at or above i_ptr, wrapping to the lowest
// set request when nothing at or above the pointer is asking.
//   i_req   - request vector, one bit per channel
//   i_ptr   - index where the search starts
//   o_grant - one-hot grant (all zero when nothing requests)
//   o_idx   - index of the granted channel
//   o_any   - at least one request is set
module bridge_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_lo_idx;
  logic [IW-1:0] w_hi_idx;
  logic          w_found_hi;

  // Scan downwards so the last hit written is the lowest index: w_hi_idx is
  // the lowest request at/above the pointer, w_lo_idx the lowest overall.
  always_comb begin
    w_lo_idx   = '0;
    w_hi_idx   = '0;
    w_found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_idx = IW'(i);
      end
      if (i_req[i] && (i >= int'(i_ptr))) begin
        w_hi_idx   = IW'(i);
        w_found_hi = 1'b1;
      end
    end
  end

  always_comb begin
    o_any   = |i_req;
    o_idx   = w_found_hi ? w_hi_idx : w_lo_idx;
    o_grant = '0;
    for (int i = 0; i < N; i++) begin
      o_grant[i] = o_any && (int'(o_idx) == i);
    end
  end

endmodule

// File: rtl/bridge_req_arbiter.sv
// bridge_req_arbiter: serialises per-channel core requests onto one driver
// port, one request outstanding at a time, round-robin between channels.
//
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high; valid never waits for ready. req_ready rises only in IDLE and only
// for the channel the picker chose. drv_valid holds with stable command data
// until drv_ready. drv_done completes the request (also accepted in the same
// cycle as drv_ready); resp_valid is a single-cycle pulse.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   req_valid/req_ready         - per-channel request handshake
//   req_cmd/req_param/req_nparam- per-channel request payload (flattened)
//   resp_valid/resp_result      - per-channel completion pulse + result
//   drv_valid/drv_ready         - driver issue handshake
//   drv_cmd/drv_param/drv_nparam- issued command payload
//   drv_done/drv_result         - driver completion
//   drv_abort                   - one-cycle abort on timeout
//   busy, grant_id              - not-idle flag, currently granted channel
//   dbg_state                   - FSM state
//
// Optional feature: define BRIDGE_REQ_ARB_TIMEOUT_EN to abort a grant that
// stays in ISSUE+WAIT for TIMEOUT_CYCLES cycles.
module bridge_req_arbiter
  import bridge_pkg::*;
#(
  parameter  int NUM_CH         = 4,
  parameter  int MAX_PARAMS     = 4,
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int PW             = $clog2(MAX_PARAMS + 1),
  localparam int GW             = gw_of(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH-1:0]                req_valid,
  output logic [NUM_CH-1:0]                req_ready,
  input  logic [NUM_CH*OPCODE_W-1:0]       req_cmd,
  input  logic [NUM_CH*MAX_PARAMS*32-1:0]  req_param,
  input  logic [NUM_CH*PW-1:0]             req_nparam,
  output logic [NUM_CH-1:0]                resp_valid,
  output logic [15:0]                      resp_result,
  output logic                             drv_valid,
  input  logic                             drv_ready,
  output logic [OPCODE_W-1:0]              drv_cmd,
  output logic [MAX_PARAMS*32-1:0]         drv_param,
  output logic [PW-1:0]                    drv_nparam,
  input  logic                             drv_done,
  input  logic [15:0]                      drv_result,
  output logic                             drv_abort,
  output logic                             busy,
  output logic [GW-1:0]                    grant_id,
  output arb_state_e                       dbg_state
);

  arb_state_e                r_state;
  arb_state_e                w_next;
  logic [GW-1:0]             r_rr_ptr;
  logic [GW-1:0]             r_grant_id;
  logic [OPCODE_W-1:0]       r_cmd;
  logic [MAX_PARAMS*32-1:0]  r_param;
  logic [PW-1:0]             r_nparam;
  logic [15:0]               r_result;

  logic [NUM_CH-1:0]         w_pick_grant;
  logic [GW-1:0]             w_pick_idx;
  logic                      w_pick_any;
  logic                      w_accept;
  logic                      w_done_now;
  logic                      w_abort;
  logic [OPCODE_W-1:0]       w_cap_cmd;
  logic [PW-1:0]             w_raw_np;
  logic [PW-1:0]             w_cap_np;
  logic [MAX_PARAMS*32-1:0]  w_cap_param;

  bridge_rr_pick #(.N(NUM_CH), .IW(GW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // In IDLE the picked channel sees ready while its valid is high, so a pick
  // is always a handshake.
  assign w_accept = (r_state == ST_IDLE) && w_pick_any;

  // Completion: done alone in WAIT, or done together with ready in ISSUE.
  assign w_done_now = ((r_state == ST_ISSUE) && drv_ready && drv_done) ||
                      ((r_state == ST_WAIT) && drv_done);

  // Payload of the picked channel; count clamped, unused words zeroed.
  always_comb begin
    w_cap_cmd   = req_cmd[int'(w_pick_idx)*OPCODE_W +: OPCODE_W];
    w_raw_np    = req_nparam[int'(w_pick_idx)*PW +: PW];
    w_cap_np    = (int'(w_raw_np) > MAX_PARAMS) ? PW'(MAX_PARAMS) : w_raw_np;
    w_cap_param = '0;
    for (int k = 0; k < MAX_PARAMS; k++) begin
      if (k < int'(w_cap_np)) begin
        w_cap_param[k*32 +: 32] = req_param[(int'(w_pick_idx)*MAX_PARAMS + k)*32 +: 32];
      end
    end
  end

`ifdef BRIDGE_REQ_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;

  // Counter holds k-1 during the k-th cycle of ISSUE+WAIT.
  assign w_tmo_hit = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  // A completion in the same cycle wins over the timeout.
  assign w_abort   = w_tmo_hit && !w_done_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if (w_accept) begin
      r_tmo_cnt <= '0;
    end else if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && !w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    drv_valid   = 1'b0;
    resp_valid  = '0;
    resp_result = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_pick_grant;
        if (w_pick_any) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        drv_valid = !w_abort;
        if (drv_ready && drv_done) w_next = ST_RESPOND;
        else if (w_abort)          w_next = ST_RESPOND;
        else if (drv_ready)        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (drv_done || w_abort) w_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        for (int i = 0; i < NUM_CH; i++) begin
          resp_valid[i] = (int'(r_grant_id) == i);
        end
        resp_result = r_result;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_cmd      <= '0;
      r_param    <= '0;
      r_nparam   <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_grant_id <= w_pick_idx;
        r_cmd      <= w_cap_cmd;
        r_param    <= w_cap_param;
        r_nparam   <= w_cap_np;
      end
      if (w_done_now) begin
        r_result <= drv_result;
      end else if (w_abort) begin
        r_result <= REQ_RESULT_TIMEOUT;
      end
      // Next search starts just past the channel that was served.
      if (r_state == ST_RESPOND) begin
        r_rr_ptr <= (int'(r_grant_id) == NUM_CH - 1) ? '0 : r_grant_id + GW'(1);
      end
    end
  end

  assign drv_cmd    = r_cmd;
  assign drv_param  = r_param;
  assign drv_nparam = r_nparam;
  assign drv_abort  = w_abort;
  assign busy       = (r_state != ST_IDLE);
  assign grant_id   = r_grant_id;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bridge_req_arbiter.sv
// tb_bridge_req_arbiter: directed bench for bridge_req_arbiter with a
// request-side driver, a driver-side device model and two expected queues
// (issued commands and completions) checked by a negedge monitor.
module tb_bridge_req_arbiter;
  import bridge_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int MAX_PARAMS = 4;
  localparam int PW         = 3;
  localparam int GW         = 2;
  localparam int TMO        = 20;
  localparam int DW         = 16 + PW + MAX_PARAMS*32;
  localparam int RW         = 4 + 16;

  logic                            clk;
  logic                            reset;
  logic [NUM_CH-1:0]               req_valid;
  logic [NUM_CH-1:0]               req_ready;
  logic [NUM_CH*16-1:0]            req_cmd;
  logic [NUM_CH*MAX_PARAMS*32-1:0] req_param;
  logic [NUM_CH*PW-1:0]            req_nparam;
  logic [NUM_CH-1:0]               resp_valid;
  logic [15:0]                     resp_result;
  logic                            drv_valid;
  logic                            drv_ready;
  logic [15:0]                     drv_cmd;
  logic [MAX_PARAMS*32-1:0]        drv_param;
  logic [PW-1:0]                   drv_nparam;
  logic                            drv_done;
  logic [15:0]                     drv_result;
  logic                            drv_abort;
  logic                            busy;
  logic [GW-1:0]                   grant_id;
  arb_state_e                      dbg_state;

  bridge_req_arbiter #(
    .NUM_CH(NUM_CH), .MAX_PARAMS(MAX_PARAMS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_param(req_param), .req_nparam(req_nparam),
    .resp_valid(resp_valid), .resp_result(resp_result),
    .drv_valid(drv_valid), .drv_ready(drv_ready), .drv_cmd(drv_cmd),
    .drv_param(drv_param), .drv_nparam(drv_nparam), .drv_done(drv_done),
    .drv_result(drv_result), .drv_abort(drv_abort),
    .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] drv_exp_q[$];
  logic [RW-1:0] exp_q[$];

  int req_left[NUM_CH];
  logic [NUM_CH-1:0] req_hs;

  int   rdy_delay, done_delay;
  bit   dev_en, dev_fixed_en;
  logic [15:0] dev_fixed;
  int   dev_cnt, dev_dcnt;
  logic [15:0] dev_res;

  int   stall_cnt, abort_cnt;
  logic prev_drv_valid;
  logic [DW-1:0] prev_drv_data;
  logic [NUM_CH-1:0] prev_resp;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] drv_item(input logic [15:0] cmd, input int np,
                                             input logic [127:0] p);
    int ne;
    logic [127:0] m;
    ne = (np > MAX_PARAMS) ? MAX_PARAMS : np;
    m  = '0;
    for (int k = 0; k < MAX_PARAMS; k++) begin
      if (k < ne) m[k*32 +: 32] = p[k*32 +: 32];
    end
    return {cmd, PW'(ne), m};
  endfunction

  task automatic expect_req(input int ch, input logic [15:0] cmd, input int np,
                            input logic [127:0] p, input logic [15:0] res);
    drv_exp_q.push_back(drv_item(cmd, np, p));
    exp_q.push_back({4'(ch), res});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_req(input int ch, input logic [15:0] cmd, input int np,
                         input logic [127:0] p, input int cnt);
    req_cmd[ch*16 +: 16]                         = cmd;
    req_nparam[ch*PW +: PW]                      = PW'(np);
    req_param[ch*MAX_PARAMS*32 +: MAX_PARAMS*32] = p;
    req_left[ch]                                 = cnt;
    req_valid[ch]                                = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) req_left[c] = 0;
    req_valid = '0;
    tick(2);
    check("rst_busy",      busy, 1'b0);
    check("rst_grant_id",  grant_id, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_drv_valid", drv_valid, 1'b0);
    check("rst_resp",      {resp_valid, resp_result}, '0);
    check("rst_drv_data",  {drv_cmd, drv_nparam, drv_param, drv_abort}, '0);
    check("rst_state",     dbg_state, ST_IDLE);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 200) begin
      tick(1);
      n++;
      pend = busy || (exp_q.size() != 0);
      for (int c = 0; c < NUM_CH; c++) if (req_left[c] != 0) pend = 1'b1;
    end
    check({tag, "_resp_q_empty"}, exp_q.size(), 0);
    check({tag, "_drv_q_empty"}, drv_exp_q.size(), 0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // Requester: holds valid while requests remain, counts handshakes.
  initial begin
    forever begin
      @(negedge clk);
      req_hs = req_valid & req_ready & {NUM_CH{!reset}};
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_hs[c] && req_left[c] > 0) req_left[c]--;
        req_valid[c] = (req_left[c] > 0) && !reset;
      end
    end
  end

  // Device model on the driver port.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      drv_ready = 1'b0;
      drv_done  = 1'b0;
      if (reset) begin
        dev_cnt  = 0;
        dev_dcnt = -1;
      end else begin
        if (dev_dcnt > 0) dev_dcnt--;
        else if (dev_dcnt == 0) begin
          drv_done   = 1'b1;
          drv_result = dev_res;
          dev_dcnt   = -1;
        end
        if (drv_valid) begin
          if (dev_cnt >= rdy_delay) begin
            drv_ready = 1'b1;
            dev_cnt   = 0;
            dev_res   = dev_fixed_en ? dev_fixed : (drv_cmd ^ 16'h5A5A);
            if (dev_en) begin
              if (done_delay == 0) begin
                drv_done   = 1'b1;
                drv_result = dev_res;
              end else begin
                dev_dcnt = done_delay - 1;
              end
            end
          end else begin
            dev_cnt++;
          end
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [DW-1:0] cur;
    logic [DW-1:0] e;
    logic [RW-1:0] r;
    logic [NUM_CH-1:0] oh;
    cur = {drv_cmd, drv_nparam, drv_param};
    if (reset) begin
      prev_drv_valid = 1'b0;
      prev_resp      = '0;
    end else begin
      if (drv_valid && !prev_drv_valid) begin
        if (drv_exp_q.size() == 0) check("drv_unexpected", drv_valid, 1'b0);
        else begin
          e = drv_exp_q.pop_front();
          check("drv_issue", cur, e);
        end
      end else if (drv_valid) begin
        check("drv_stable", cur, prev_drv_data);
      end
      if (drv_valid && !drv_ready) stall_cnt++;
      if (drv_abort) abort_cnt++;
      if (resp_valid != '0) begin
        check("resp_single_pulse", prev_resp, '0);
        if (exp_q.size() == 0) check("resp_unexpected", resp_valid, '0);
        else begin
          r  = exp_q.pop_front();
          oh = '0;
          oh[r[19:16]] = 1'b1;
          check("resp_channel", resp_valid, oh);
          check("resp_result", resp_result, r[15:0]);
        end
      end
      prev_drv_valid = drv_valid;
      prev_resp      = resp_valid;
    end
    prev_drv_data = cur;
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; req_valid = '0; req_cmd = '0; req_param = '0; req_nparam = '0;
    drv_ready = 1'b0; drv_done = 1'b0; drv_result = '0;
    rdy_delay = 0; done_delay = 0; dev_en = 1'b1; dev_fixed_en = 1'b0; dev_fixed = '0;
    dev_cnt = 0; dev_dcnt = -1; dev_res = '0; stall_cnt = 0; abort_cnt = 0;
    prev_drv_valid = 1'b0; prev_resp = '0; prev_drv_data = '0; req_hs = '0;
    for (int c = 0; c < NUM_CH; c++) req_left[c] = 0;

    // Three simultaneous requests on 0/2/3, immediate driver.
    do_reset();
    expect_req(0, 16'h0010, 1, 128'h0000000400000003_0000000200000001, 16'h0010 ^ 16'h5A5A);
    expect_req(2, 16'h0020, 4, 128'hDDDDDDDDCCCCCCCC_BBBBBBBBAAAAAAAA, 16'h0020 ^ 16'h5A5A);
    expect_req(3, 16'h0030, 0, 128'h1111111122222222_3333333344444444, 16'h0030 ^ 16'h5A5A);
    set_req(0, 16'h0010, 1, 128'h0000000400000003_0000000200000001, 1);
    set_req(2, 16'h0020, 4, 128'hDDDDDDDDCCCCCCCC_BBBBBBBBAAAAAAAA, 1);
    set_req(3, 16'h0030, 0, 128'h1111111122222222_3333333344444444, 1);
    #1;
    check("first_pick_ready", req_ready, 4'b0001);
    tick(1);
    check("issue_drv_valid", drv_valid, 1'b1);
    check("issue_grant_id", grant_id, 2'd0);
    check("issue_req_ready_low", req_ready, '0);
    tick(1);
    check("min_latency_resp", resp_valid, 4'b0001);
    wait_drain("order_023");
    check("last_grant", grant_id, 2'd3);

    // Channels 1 and 3 held valid: must alternate.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      expect_req(1, 16'h0101, 2, 128'h0, 16'h0101 ^ 16'h5A5A);
      expect_req(3, 16'h0303, 3, 128'h0, 16'h0303 ^ 16'h5A5A);
    end
    set_req(1, 16'h0101, 2, 128'h0, 3);
    set_req(3, 16'h0303, 3, 128'h0, 3);
    wait_drain("alternate_1_3");

    // Parameter count clamping and zeroing of unused words.
    do_reset();
    expect_req(2, 16'h0180, 6, 128'h44444444_33333333_22222222_11111111, 16'h0180 ^ 16'h5A5A);
    set_req(2, 16'h0180, 6, 128'h44444444_33333333_22222222_11111111, 1);
    wait_drain("clamp_np6");
    expect_req(1, 16'h0042, 2, 128'hFFFFFFFF_EEEEEEEE_99999999_88888888, 16'h0042 ^ 16'h5A5A);
    set_req(1, 16'h0042, 2, 128'hFFFFFFFF_EEEEEEEE_99999999_88888888, 1);
    wait_drain("zero_np2");
    expect_req(0, 16'h0043, 4, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 16'h0043 ^ 16'h5A5A);
    set_req(0, 16'h0043, 4, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 1);
    wait_drain("np_equal_max");

    // Driver stalls five cycles, completes later with a fixed result.
    do_reset();
    rdy_delay = 5; done_delay = 2; dev_fixed_en = 1'b1; dev_fixed = 16'h0002;
    stall_cnt = 0;
    expect_req(3, 16'h0777, 3, 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF, 16'h0002);
    set_req(3, 16'h0777, 3, 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF, 1);
    wait_drain("stall5");
    check("stall_cycles", stall_cnt, 5);
    rdy_delay = 0; done_delay = 0; dev_fixed_en = 1'b0;

    // Stray drv_done while idle must not produce a response.
    drv_done = 1'b1; drv_result = 16'h1234;
    tick(3);
    check("idle_done_ignored", {busy, resp_valid}, '0);

    // Reset while waiting for completion.
    do_reset();
    dev_en = 1'b0;
    drv_exp_q.push_back(drv_item(16'h0999, 1, 128'h5));
    set_req(1, 16'h0999, 1, 128'h5, 1);
    tick(4);
    check("wait_state", dbg_state, ST_WAIT);
    check("wait_drv_valid", drv_valid, 1'b0);
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) req_left[c] = 0;
    req_valid = '0;
    tick(1);
    check("mid_reset_state", dbg_state, ST_IDLE);
    check("mid_reset_outputs", {drv_valid, resp_valid, busy, grant_id}, '0);
    reset = 1'b0;
    dev_en = 1'b1;
    tick(5);
    check("mid_reset_no_resp", {busy, resp_valid}, '0);
    wait_drain("after_reset");

`ifdef BRIDGE_REQ_ARB_TIMEOUT_EN
    // Timeout: no completion, abort on the 20th ISSUE+WAIT cycle.
    do_reset();
    dev_en = 1'b0; abort_cnt = 0;
    expect_req(0, 16'h0ABC, 1, 128'h7, 16'hFFFF);
    set_req(0, 16'h0ABC, 1, 128'h7, 1);
    tick(19);
    check("tmo_no_abort_yet", drv_abort, 1'b0);
    tick(1);
    check("tmo_abort_pulse", {drv_abort, drv_valid}, 2'b10);
    tick(1);
    check("tmo_respond", {resp_valid, resp_result}, {4'b0001, 16'hFFFF});
    tick(1);
    drv_done = 1'b1; drv_result = 16'h5555;
    tick(3);
    check("tmo_late_done_ignored", {busy, resp_valid}, '0);
    wait_drain("timeout");
    check("tmo_abort_count", abort_cnt, 1);

    // Completion in the timeout cycle wins.
    do_reset();
    dev_en = 1'b1; done_delay = 19; abort_cnt = 0;
    expect_req(2, 16'h0BCD, 0, 128'h0, 16'h0BCD ^ 16'h5A5A);
    set_req(2, 16'h0BCD, 0, 128'h0, 1);
    wait_drain("tmo_vs_done");
    check("tmo_vs_done_no_abort", abort_cnt, 0);
    done_delay = 0;
`else
    check("abort_never", abort_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
